branch_sched: RTL and testbench

BRANCH_SCHED -- requirements
Module: branch_sched

---
 rtl/ariane_pkg.sv | 40 ++++
 rtl/riscv.sv | 7 +
 rtl/fifo_v3.sv | 65 ++++++
 rtl/branch_sched.sv | 141 ++++++++++++++
 tb/tb_branch_sched.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - functional-unit, prediction and branch-queue entry types
package ariane_pkg;

  localparam int unsigned TRANS_ID_BITS = 3;

  typedef enum logic [3:0] {
    NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR
  } fu_t;

  typedef enum logic [3:0] {
    ADD, EQ, NE, LTS, GES, LTU, GEU, JALR
  } fu_op;

  typedef struct packed {
    fu_t                        fu;
    fu_op                       operation;
    logic [riscv::XLEN-1:0]     operand_a;
    logic [riscv::XLEN-1:0]     operand_b;
    logic [riscv::XLEN-1:0]     imm;
    logic [TRANS_ID_BITS-1:0]   trans_id;
  } fu_data_t;

  typedef enum logic [2:0] {
    NoCF, Branch, Jump, JumpR, Return
  } cf_t;

  typedef struct packed {
    cf_t                    cf;
    logic [riscv::VLEN-1:0] predict_address;
  } branchpredict_sbe_t;

  // One queued branch/jump op waiting for its comparison.
  typedef struct packed {
    fu_data_t               fu_data;
    logic [riscv::VLEN-1:0] pc;
    logic                   is_compressed;
    branchpredict_sbe_t     predict;
  } branch_sched_entry_t;

endpackage

// File: rtl/riscv.sv
// rtl/riscv.sv - RISC-V architectural widths shared by the branch scheduler slice
package riscv;

  localparam int unsigned XLEN = 64;
  localparam int unsigned VLEN = 64;

endpackage

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - circular FIFO with synchronous flush and occupancy count
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   flush_i           empty the FIFO at the next edge (wins over push/pop)
//   push_i, data_i    write an entry (ignored while full)
//   pop_i             drop the head entry (ignored while empty)
//   data_o            head entry (raw storage, not gated when empty)
//   full_o, empty_o   status
//   usage_o           number of stored entries, 0..DEPTH
module fifo_v3 #(
  parameter int unsigned DEPTH = 4,
  parameter type dtype = logic,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W  = ADDR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  dtype             data_i,
  input  logic             pop_i,
  output dtype             data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] usage_o
);

  dtype              mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (cnt == CNT_W'(DEPTH));
  assign empty_o = (cnt == '0);
  assign usage_o = cnt;
  assign data_o  = mem[rd_ptr];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      if (do_push && !do_pop)      cnt <= cnt + CNT_W'(1);
      else if (do_pop && !do_push) cnt <= cnt - CNT_W'(1);
    end
  end

  // Storage needs no reset: nothing reads it until an entry is counted.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/branch_sched.sv
// rtl/branch_sched.sv - branch queue that borrows the shared ALU comparator per op
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_i                  kill all queued and in-flight branches
//   issue_*                  op offered by issue (valid/ready handshake)
//   alu_req_o, alu_gnt_i     comparator request/grant for the head op
//   alu_cmp_valid_i/res_i    comparator result (1 = taken)
//   bu_*_o                   head entry and resolve strobe to the branch unit
//   bu_mispredict_i          branch unit flags the resolving op as mispredicted
//   mispredict_flush_o       younger queued entries are being discarded
//   busy_o                   queue non-empty or an op is in flight
module branch_sched
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   issue_valid_i,
  output logic                   issue_ready_o,
  input  fu_data_t               issue_fu_data_i,
  input  logic [riscv::VLEN-1:0] issue_pc_i,
  input  logic                   issue_is_compressed_i,
  input  branchpredict_sbe_t     issue_predict_i,
  output logic                   alu_req_o,
  input  logic                   alu_gnt_i,
  input  logic                   alu_cmp_valid_i,
  input  logic                   alu_cmp_res_i,
  output fu_data_t               bu_fu_data_o,
  output logic [riscv::VLEN-1:0] bu_pc_o,
  output logic                   bu_is_compressed_o,
  output branchpredict_sbe_t     bu_predict_o,
  output logic                   bu_branch_valid_o,
  output logic                   bu_cmp_res_o,
  input  logic                   bu_mispredict_i,
  output logic                   mispredict_flush_o,
  output logic                   busy_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESOLVE} state_e;

  state_e              state_q, state_d;
  logic                cmp_res_q, cmp_res_d;
  logic                drop_q, drop_d;
  logic                full, empty;
  logic [CNT_W-1:0]    count;
  logic                push, pop, mis_clear;
  branch_sched_entry_t push_entry, head_entry, head_vis;

  assign push_entry = '{
    fu_data:       issue_fu_data_i,
    pc:            issue_pc_i,
    is_compressed: issue_is_compressed_i,
    predict:       issue_predict_i
  };

  // Held low during reset so every output reads zero while rst_ni is low.
  assign issue_ready_o = rst_ni & ~full & (state_q != RESOLVE);
  assign push          = issue_valid_i & issue_ready_o;
  assign pop           = (state_q == RESOLVE);
  assign mis_clear     = (state_q == RESOLVE) & bu_mispredict_i;

  fifo_v3 #(
    .DEPTH (DEPTH),
    .dtype (branch_sched_entry_t)
  ) i_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i | mis_clear),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .full_o  (full),
    .empty_o (empty),
    .usage_o (count)
  );

  assign head_vis           = empty ? '0 : head_entry;
  assign bu_fu_data_o       = head_vis.fu_data;
  assign bu_pc_o            = head_vis.pc;
  assign bu_is_compressed_o = head_vis.is_compressed;
  assign bu_predict_o       = head_vis.predict;
  assign bu_cmp_res_o       = cmp_res_q;
  assign mispredict_flush_o = mis_clear;
  assign busy_o             = (state_q != IDLE) | (count != '0);

  always_comb begin
    state_d           = state_q;
    cmp_res_d         = cmp_res_q;
    drop_d            = drop_q;
    alu_req_o         = 1'b0;
    bu_branch_valid_o = 1'b0;

    case (state_q)
      IDLE:    if (count != '0) state_d = REQ;
      REQ: begin
        alu_req_o = 1'b1;
        // A result still owed to a killed op would be mistaken for ours.
        if (alu_gnt_i && !drop_q) state_d = WAIT;
      end
      WAIT: begin
        if (alu_cmp_valid_i) begin
          cmp_res_d = alu_cmp_res_i;
          state_d   = RESOLVE;
        end
      end
      RESOLVE: begin
        bu_branch_valid_o = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (drop_q && alu_cmp_valid_i) drop_d = 1'b0;

    if (flush_i) begin
      state_d   = IDLE;
      cmp_res_d = cmp_res_q;
      // The ALU still owes a result if it granted and has not answered yet.
      if ((state_q == WAIT && !alu_cmp_valid_i) || (state_q == REQ && alu_gnt_i))
        drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cmp_res_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmp_res_q <= cmp_res_d;
      drop_q    <= drop_d;
    end
  end

endmodule

// File: tb/tb_branch_sched.sv
// tb/tb_branch_sched.sv - self-checking bench for branch_sched
module tb_branch_sched;
  import ariane_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_RES = 3;

  logic                   clk = 1'b0;
  logic                   rst_ni = 1'b0;
  logic                   flush_i = 1'b0;
  logic                   issue_valid_i = 1'b0;
  logic                   issue_ready_o;
  fu_data_t               issue_fu_data_i = '0;
  logic [riscv::VLEN-1:0] issue_pc_i = '0;
  logic                   issue_is_compressed_i = 1'b0;
  branchpredict_sbe_t     issue_predict_i = '0;
  logic                   alu_req_o, alu_gnt_i, alu_cmp_valid_i, alu_cmp_res_i;
  fu_data_t               bu_fu_data_o;
  logic [riscv::VLEN-1:0] bu_pc_o;
  logic                   bu_is_compressed_o;
  branchpredict_sbe_t     bu_predict_o;
  logic                   bu_branch_valid_o, bu_cmp_res_o;
  logic                   bu_mispredict_i = 1'b0;
  logic                   mispredict_flush_o, busy_o;

  // ALU stand-in: automatic mode grants at once and answers one cycle later
  // with operand_a == operand_b; manual mode is driven by the stimulus.
  logic auto_alu = 1'b1, man_gnt = 1'b0, man_cmp_valid = 1'b0, man_res = 1'b0, pend = 1'b0;
  assign alu_gnt_i       = auto_alu ? alu_req_o : man_gnt;
  assign alu_cmp_valid_i = auto_alu ? pend : man_cmp_valid;
  assign alu_cmp_res_i   = auto_alu ? (bu_fu_data_o.operand_a == bu_fu_data_o.operand_b) : man_res;
  always @(posedge clk) pend <= rst_ni && alu_req_o && alu_gnt_i;

  branch_sched #(.DEPTH(DEPTH)) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_ni),
    .flush_i               (flush_i),
    .issue_valid_i         (issue_valid_i),
    .issue_ready_o         (issue_ready_o),
    .issue_fu_data_i       (issue_fu_data_i),
    .issue_pc_i            (issue_pc_i),
    .issue_is_compressed_i (issue_is_compressed_i),
    .issue_predict_i       (issue_predict_i),
    .alu_req_o             (alu_req_o),
    .alu_gnt_i             (alu_gnt_i),
    .alu_cmp_valid_i       (alu_cmp_valid_i),
    .alu_cmp_res_i         (alu_cmp_res_i),
    .bu_fu_data_o          (bu_fu_data_o),
    .bu_pc_o               (bu_pc_o),
    .bu_is_compressed_o    (bu_is_compressed_o),
    .bu_predict_o          (bu_predict_o),
    .bu_branch_valid_o     (bu_branch_valid_o),
    .bu_cmp_res_o          (bu_cmp_res_o),
    .bu_mispredict_i       (bu_mispredict_i),
    .mispredict_flush_o    (mispredict_flush_o),
    .busy_o                (busy_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: the queue is a plain list of entries, and the op at the
  // front walks through four phases (idle, asking ALU, waiting, resolving).
  branch_sched_entry_t m_q[$];
  int                  m_ph = P_IDLE;
  logic                m_res = 1'b0;
  logic                m_drop = 1'b0;

  always @(negedge clk) begin
    branch_sched_entry_t head;
    logic                e_ready, old_drop;
    int                  had;
    if (!rst_ni) begin
      m_q.delete();
      m_ph   = P_IDLE;
      m_res  = 1'b0;
      m_drop = 1'b0;
    end
    head = '0;
    if (m_q.size() != 0) head = m_q[0];
    e_ready = rst_ni && (m_q.size() < DEPTH) && (m_ph != P_RES);
    check("issue_ready", 256'(issue_ready_o), 256'(e_ready));
    check("alu_req", 256'(alu_req_o), 256'(m_ph == P_REQ));
    check("branch_valid", 256'(bu_branch_valid_o), 256'(m_ph == P_RES));
    check("mispredict_flush", 256'(mispredict_flush_o), 256'(m_ph == P_RES && bu_mispredict_i));
    check("busy", 256'(busy_o), 256'(m_ph != P_IDLE || m_q.size() != 0));
    check("cmp_res", 256'(bu_cmp_res_o), 256'(m_res));
    check("head_pc", 256'(bu_pc_o), 256'(head.pc));
    check("head_fu_data", 256'(bu_fu_data_o), 256'(head.fu_data));
    check("head_compressed", 256'(bu_is_compressed_o), 256'(head.is_compressed));
    check("head_predict", 256'(bu_predict_o), 256'(head.predict));

    if (rst_ni) begin
      had      = m_q.size();
      old_drop = m_drop;
      if (flush_i) begin
        if ((m_ph == P_WAIT && !alu_cmp_valid_i) || (m_ph == P_REQ && alu_gnt_i)) m_drop = 1'b1;
        else if (alu_cmp_valid_i) m_drop = 1'b0;
        m_q.delete();
        m_ph = P_IDLE;
      end else begin
        if (alu_cmp_valid_i) m_drop = 1'b0;
        case (m_ph)
          P_IDLE: if (had != 0) m_ph = P_REQ;
          P_REQ:  if (alu_gnt_i && !old_drop) m_ph = P_WAIT;
          P_WAIT: if (alu_cmp_valid_i) begin m_res = alu_cmp_res_i; m_ph = P_RES; end
          default: begin
            void'(m_q.pop_front());
            if (bu_mispredict_i) m_q.delete();
            m_ph = P_IDLE;
          end
        endcase
        if (issue_valid_i && e_ready)
          m_q.push_back('{fu_data: issue_fu_data_i, pc: issue_pc_i,
                         is_compressed: issue_is_compressed_i, predict: issue_predict_i});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [63:0] pc, input logic [63:0] a, input logic [63:0] b, input logic c);
    issue_valid_i                    = 1'b1;
    issue_pc_i                       = pc;
    issue_fu_data_i                  = '0;
    issue_fu_data_i.fu               = CTRL_FLOW;
    issue_fu_data_i.operation        = EQ;
    issue_fu_data_i.operand_a        = a;
    issue_fu_data_i.operand_b        = b;
    issue_fu_data_i.imm              = 64'h10;
    issue_fu_data_i.trans_id         = a[2:0];
    issue_is_compressed_i            = c;
    issue_predict_i.cf               = Branch;
    issue_predict_i.predict_address  = pc + 64'h10;
  endtask

  task automatic wait_req();
    int k = 0;
    while (!alu_req_o && k < 20) begin step(); k++; end
    check("wait_req_bound", 256'(alu_req_o), 256'(1));
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy_o && k < 50) begin step(); k++; end
    check("wait_idle_bound", 256'(busy_o), 256'(0));
  endtask

  logic [63:0] pcs [4];
  int cyc, nres;

  initial begin
    pcs[0] = 64'h8000_1000; pcs[1] = 64'h8000_1004;
    pcs[2] = 64'h8000_1008; pcs[3] = 64'h8000_100c;

    // Reset state
    step();
    check("rst_busy", 256'(busy_o), 256'(0));
    check("rst_ready", 256'(issue_ready_o), 256'(0));
    check("rst_pc", 256'(bu_pc_o), 256'(0));
    rst_ni = 1'b1;
    #1;
    check("rel_ready", 256'(issue_ready_o), 256'(1));
    check("rel_busy", 256'(busy_o), 256'(0));
    step();

    // Single BEQ, minimum latency
    offer(64'h8000_0000, 64'd5, 64'd5, 1'b0);
    step();
    issue_valid_i = 1'b0;
    cyc = 1;
    while (!bu_branch_valid_o && cyc < 20) begin step(); cyc++; end
    check("t1_latency", 256'(cyc), 256'(4));
    check("t1_cmp_res", 256'(bu_cmp_res_o), 256'(1));
    check("t1_pc", 256'(bu_pc_o), 256'(64'h8000_0000));
    step();

    // Four back-to-back ops fill the queue; resolves every 4 cycles in order
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      offer(pcs[i], 64'(i), (i % 2 == 0) ? 64'(i) : 64'(i + 7), i[0]);
      check("t2_ready", 256'(issue_ready_o), 256'(1));
      step();
    end
    offer(64'h8000_2000, 64'd9, 64'd9, 1'b0);
    check("t2_fifth_ready", 256'(issue_ready_o), 256'(0));
    nres = 0;
    for (int c = 4; c < 24; c++) begin
      if (bu_branch_valid_o && nres < 4) begin
        check("t2_resolve_cycle", 256'(c), 256'(4 + 4 * nres));
        check("t2_resolve_pc", 256'(bu_pc_o), 256'(pcs[nres]));
        check("t2_resolve_cmp", 256'(bu_cmp_res_o), 256'(nres % 2 == 0));
        nres++;
      end
      step();
      issue_valid_i = 1'b0;
    end
    check("t2_resolve_count", 256'(nres), 256'(4));

    // Mispredict on the first of three queued ops
    wait_idle();
    bu_mispredict_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(pcs[i], 64'd1, 64'd1, 1'b0);
      step();
    end
    issue_valid_i = 1'b0;
    cyc = 3;
    while (!bu_branch_valid_o && cyc < 20) begin step(); cyc++; end
    check("t3_latency", 256'(cyc), 256'(4));
    check("t3_mispredict_flush", 256'(mispredict_flush_o), 256'(1));
    step();
    check("t3_busy_after", 256'(busy_o), 256'(0));
    nres = 0;
    repeat (8) begin
      step();
      if (bu_branch_valid_o) nres++;
    end
    check("t3_no_more_resolves", 256'(nres), 256'(0));
    bu_mispredict_i = 1'b0;

    // Flush in WAIT; stale result arrives two cycles later
    auto_alu = 1'b0;
    offer(64'h8000_0100, 64'd3, 64'd3, 1'b0);
    step();
    issue_valid_i = 1'b0;
    wait_req();
    man_gnt = 1'b1;
    step();
    man_gnt = 1'b0;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    offer(64'h8000_0200, 64'd4, 64'd6, 1'b1);
    step();
    issue_valid_i = 1'b0;
    man_cmp_valid = 1'b1;
    man_res       = 1'b1;
    step();
    man_cmp_valid = 1'b0;
    check("t4a_new_req", 256'(alu_req_o), 256'(1));
    man_gnt = 1'b1;
    step();
    man_gnt = 1'b0;
    check("t4a_waiting", 256'(bu_branch_valid_o), 256'(0));
    man_cmp_valid = 1'b1;
    man_res       = 1'b0;
    step();
    man_cmp_valid = 1'b0;
    check("t4a_resolve", 256'(bu_branch_valid_o), 256'(1));
    check("t4a_cmp_res", 256'(bu_cmp_res_o), 256'(0));
    check("t4a_pc", 256'(bu_pc_o), 256'(64'h8000_0200));
    step();

    // Flush in REQ with grant; REQ must stall until the stale result drains
    offer(64'h8000_0300, 64'd2, 64'd2, 1'b0);
    step();
    issue_valid_i = 1'b0;
    wait_req();
    man_gnt = 1'b1;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    offer(64'h8000_0400, 64'd8, 64'd5, 1'b0);
    step();
    issue_valid_i = 1'b0;
    step();
    check("t4b_req", 256'(alu_req_o), 256'(1));
    man_cmp_valid = 1'b1;
    man_res       = 1'b1;
    step();
    man_cmp_valid = 1'b0;
    check("t4b_req_blocked", 256'(alu_req_o), 256'(1));
    step();
    check("t4b_now_wait", 256'(alu_req_o), 256'(0));
    man_gnt       = 1'b0;
    man_cmp_valid = 1'b1;
    man_res       = 1'b0;
    step();
    man_cmp_valid = 1'b0;
    check("t4b_resolve", 256'(bu_branch_valid_o), 256'(1));
    check("t4b_cmp_res", 256'(bu_cmp_res_o), 256'(0));
    check("t4b_pc", 256'(bu_pc_o), 256'(64'h8000_0400));
    step();

    // Reset in the middle of WAIT
    offer(64'h8000_0500, 64'd1, 64'd1, 1'b0);
    step();
    issue_valid_i = 1'b0;
    wait_req();
    man_gnt = 1'b1;
    step();
    man_gnt = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check("t5_busy", 256'(busy_o), 256'(0));
    check("t5_alu_req", 256'(alu_req_o), 256'(0));
    check("t5_ready", 256'(issue_ready_o), 256'(0));
    check("t5_pc", 256'(bu_pc_o), 256'(0));
    check("t5_cmp_res", 256'(bu_cmp_res_o), 256'(0));
    step();
    step();
    rst_ni = 1'b1;
    #1;
    check("t5_rel_ready", 256'(issue_ready_o), 256'(1));
    check("t5_rel_busy", 256'(busy_o), 256'(0));
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got no finish expected finish before 50000");
    $fatal(1, "watchdog");
  end

endmodule
